board_lock_clear: RTL and testbench

//  Consumer of the active-piece overlay (next_write, 22 rows x 10 cols) produced by the write mux.
//  On lock_req, ORs the overlay into the locked playfield it owns.

---
 rtl/tetris_pkg.sv | 30 +++
 rtl/board_lock_clear_row_shift_down.sv | 27 ++
 rtl/board_lock_clear.sv | 134 +++++++++++++
 tb/tb_board_lock_clear.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield definitions for the Tetris datapath.
// Provides the board geometry, the row/board types, the lock-and-clear
// FSM state encoding, and a saturating adder for the line counter.
package tetris_pkg;

    localparam int ROWS     = 22;  // row ROWS-1 is the top, row 0 the bottom
    localparam int COLS     = 10;
    localparam int VIS_ROWS = 20;  // rows VIS_ROWS..ROWS-1 are the hidden spawn rows
    localparam int LINES_W  = 16;
    localparam int R_W      = $clog2(ROWS);

    typedef logic [COLS-1:0] row_t;
    typedef row_t [ROWS-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } lock_state_e;

    // Running line total sticks at all-ones rather than wrapping.
    function automatic logic [LINES_W-1:0] sat_add(input logic [LINES_W-1:0] a,
                                                   input logic [2:0]         b);
        logic [LINES_W:0] sum;
        sum = {1'b0, a} + (LINES_W + 1)'(b);
        return sum[LINES_W] ? '1 : sum[LINES_W-1:0];
    endfunction

endpackage

// File: rtl/board_lock_clear_row_shift_down.sv
// row_shift_down: purely combinational line removal.
// Removes row r_i from the board: every row at or above r_i takes the
// contents of the row directly above it, and the top row becomes empty.
// Rows below r_i pass through untouched.
//   board_i  in   board_t    current locked playfield
//   r_i      in   [R_W-1:0]  index of the row being removed
//   board_o  out  board_t    playfield with row r_i removed
module row_shift_down
    import tetris_pkg::*;
(
    input  board_t         board_i,
    input  logic [R_W-1:0] r_i,
    output board_t         board_o
);

    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        board_o = board_i;
        for (int i = 0; i < ROWS - 1; i++) begin
            if (R_W'(i) >= r_i) begin
                board_o[i] = board_i[i + 1];
            end
        end
        board_o[ROWS-1] = '0;
    end

endmodule

// File: rtl/board_lock_clear.sv
// board_lock_clear: owns the locked playfield.
// On lock_req the active-piece overlay is ORed into the board, then the board
// is scanned bottom-up one row per cycle; each full row is removed and the row
// that drops into its place is re-examined. Reports rows cleared per lock, a
// saturating running total, and a sticky game-over flag.
//   Clk           in   1                  rising-edge clock
//   Reset_n       in   1                  asynchronous active-low reset
//   lock_req      in   1                  piece landed; merge active_piece
//   clear_board   in   1                  wipe board/total/game_over (IDLE only)
//   active_piece  in   board_t            overlay, sampled during MERGE
//   board         out  board_t            locked playfield (registered)
//   busy          out  1                  high MERGE..DONE
//   done          out  1                  1-cycle pulse in DONE
//   lines_last    out  3                  rows cleared by the latest lock
//   lines_total   out  LINES_W            saturating running total
//   game_over     out  1                  sticky overlap / overflow flag
module board_lock_clear
    import tetris_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               lock_req,
    input  logic               clear_board,
    input  board_t             active_piece,
    output board_t             board,
    output logic               busy,
    output logic               done,
    output logic [2:0]         lines_last,
    output logic [LINES_W-1:0] lines_total,
    output logic               game_over
);

    lock_state_e        state_q, state_d;
    board_t             board_q, board_d;
    logic [R_W-1:0]     r_q, r_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2:0]         lines_last_q, lines_last_d;
    logic [LINES_W-1:0] lines_total_q, lines_total_d;
    logic               game_over_q, game_over_d;

    board_t             board_shifted;

    row_shift_down u_row_shift_down (
        .board_i (board_q),
        .r_i     (r_q),
        .board_o (board_shifted)
    );

    always_comb begin
        // NOTE: next-state logic uses blocking '='; only the clocked block below uses '<='.
        state_d       = state_q;
        board_d       = board_q;
        r_d           = r_q;
        cnt_d         = cnt_q;
        lines_last_d  = lines_last_q;
        lines_total_d = lines_total_q;
        game_over_d   = game_over_q;

        case (state_q)
            IDLE: begin
                if (clear_board) begin
                    board_d       = '0;
                    lines_total_d = '0;
                    game_over_d   = 1'b0;
                end else if (lock_req) begin
                    state_d = MERGE;
                end
            end

            MERGE: begin
                board_d = board_q | active_piece;
                // Any cell claimed by both the board and the piece is an illegal spawn.
                if (|(board_q & active_piece)) begin
                    game_over_d = 1'b1;
                end
                r_d     = '0;
                cnt_d   = '0;
                state_d = SCAN;
            end

            SCAN: begin
                if (&board_q[r_q]) begin
                    // Keep r: the row that just dropped into r may be full too.
                    board_d = board_shifted;
                    cnt_d   = cnt_q + 3'd1;
                end else if (r_q == R_W'(ROWS - 1)) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q + R_W'(1);
                end
            end

            DONE: begin
                lines_last_d  = cnt_q;
                lines_total_d = sat_add(lines_total_q, cnt_q);
                if (|board_q[ROWS-1:VIS_ROWS]) begin
                    game_over_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the board is a flop array, not a RAM, so resetting it is both legal and required.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            board_q       <= '0;
            r_q           <= '0;
            cnt_q         <= '0;
            lines_last_q  <= '0;
            lines_total_q <= '0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            r_q           <= r_d;
            cnt_q         <= cnt_d;
            lines_last_q  <= lines_last_d;
            lines_total_q <= lines_total_d;
            game_over_q   <= game_over_d;
        end
    end

    assign board       = board_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign lines_last  = lines_last_q;
    assign lines_total = lines_total_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_board_lock_clear.sv
module tb_board_lock_clear;
    import tetris_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               lock_req = 1'b0;
    logic               clear_board = 1'b0;
    board_t             active_piece = '0;
    board_t             board;
    logic               busy;
    logic               done;
    logic [2:0]         lines_last;
    logic [LINES_W-1:0] lines_total;
    logic               game_over;

    board_lock_clear dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .lock_req     (lock_req),
        .clear_board  (clear_board),
        .active_piece (active_piece),
        .board        (board),
        .busy         (busy),
        .done         (done),
        .lines_last   (lines_last),
        .lines_total  (lines_total),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 t0;
        int                 lat;
        board_t             brd;
        logic [2:0]         ll;
        logic [LINES_W-1:0] tot;
        logic               go;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_seen = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse; results are checked the
    // cycle after DONE, once the DONE-cycle register updates have landed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_latency", cyc - e.t0, e.lat);
                    check("busy_in_done", busy, 1'b1);
                    @(negedge clk);
                    check("done_pulse_width", done, 1'b0);
                    check("busy_after_done", busy, 1'b0);
                    check("lines_last", lines_last, e.ll);
                    check("lines_total", lines_total, e.tot);
                    check("game_over", game_over, e.go);
                    check("board", board, e.brd);
                end
                done_seen++;
            end
        end
    end

    // Pulse lock_req; active_piece is held through the MERGE cycle.
    task automatic lock_start(input board_t piece, input bit push, input int lat,
                              input board_t brd, input logic [2:0] ll,
                              input logic [LINES_W-1:0] tot, input logic go);
        exp_t e;
        @(negedge clk);
        active_piece = piece;
        lock_req     = 1'b1;
        e.t0 = cyc; e.lat = lat; e.brd = brd; e.ll = ll; e.tot = tot; e.go = go;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        lock_req = 1'b0;
        @(negedge clk);
        active_piece = '0;
    endtask

    task automatic wait_done(input int prev);
        bit seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (done_seen > prev) seen = 1;
        end
        if (!seen) check("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic do_lock(input board_t piece, input int lat, input board_t brd,
                           input logic [2:0] ll, input logic [LINES_W-1:0] tot, input logic go);
        int prev;
        prev = done_seen;
        lock_start(piece, 1, lat, brd, ll, tot, go);
        wait_done(prev);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_board = 1'b1;
        @(negedge clk);
        clear_board = 1'b0;
        check("clear_board_board", board, '0);
        check("clear_board_total", lines_total, '0);
        check("clear_board_go", game_over, 1'b0);
    endtask

    initial begin
        board_t p, b;
        int     prev;

        #1;
        check("reset_board", board, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_lines_last", lines_last, 3'd0);
        check("reset_lines_total", lines_total, '0);
        check("reset_game_over", game_over, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Plain drop, nothing cleared.
        p = '0; p[0] = 10'h00F; p[1] = 10'h00F;
        do_lock(p, 24, p, 3'd0, 16'd0, 1'b0);
        do_clear();

        // Single clear: row 1 drops into row 0.
        p = '0; p[0] = 10'h3F0;
        do_lock(p, 24, p, 3'd0, 16'd0, 1'b0);
        p = '0; p[0] = 10'h00F; p[1] = 10'h001;
        b = '0; b[0] = 10'h001;
        do_lock(p, 25, b, 3'd1, 16'd1, 1'b0);
        do_clear();

        // Tetris: four adjacent full rows.
        p = '0; for (int i = 0; i < 4; i++) p[i] = 10'h3FE;
        do_lock(p, 24, p, 3'd0, 16'd0, 1'b0);
        p = '0; for (int i = 0; i < 4; i++) p[i] = 10'h001;
        do_lock(p, 28, '0, 3'd4, 16'd4, 1'b0);

        // Non-adjacent full rows 0 and 2.
        p = '0; p[0] = 10'h3FF; p[1] = 10'h155; p[2] = 10'h3FF;
        b = '0; b[0] = 10'h155;
        do_lock(p, 26, b, 3'd2, 16'd6, 1'b0);

        // Reset asserted mid-SCAN with a non-empty board and non-zero total.
        p = '0; p[5] = 10'h001;
        lock_start(p, 0, 0, '0, 3'd0, 16'd0, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midscan_reset_board", board, '0);
        check("midscan_reset_busy", busy, 1'b0);
        check("midscan_reset_total", lines_total, '0);
        check("midscan_reset_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Piece locked in the hidden spawn rows.
        p = '0; p[20] = 10'h030; p[21] = 10'h030;
        do_lock(p, 24, p, 3'd0, 16'd0, 1'b1);
        do_clear();

        // Overlapping merge, with lock_req and clear_board pulsed while busy.
        p = '0; p[0] = 10'h00F;
        do_lock(p, 24, p, 3'd0, 16'd0, 1'b0);
        prev = done_seen;
        b = p;
        p = '0; p[0] = 10'h001;
        exp_q.push_back('{cyc + 1, 24, b, 3'd0, 16'd0, 1'b1});
        @(negedge clk);
        active_piece = p;
        lock_req     = 1'b1;
        @(negedge clk);
        lock_req = 1'b0;
        check("merge_busy", busy, 1'b1);
        check("go_before_merge_edge", game_over, 1'b0);
        @(negedge clk);
        active_piece = '0;
        check("overlap_go_after_merge", game_over, 1'b1);
        lock_req    = 1'b1;
        clear_board = 1'b1;
        @(negedge clk);
        lock_req    = 1'b0;
        clear_board = 1'b0;
        check("busy_ignores_clear", game_over, 1'b1);
        wait_done(prev);
        repeat (3) @(negedge clk);
        check("no_queued_lock", busy, 1'b0);
        do_clear();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
